// File: rtl/bcd_ascii_streamer.sv
// Streams a captured packed-BCD string as ASCII digits, MSD first, followed by CR LF.
// Optional build macro BCD_LZ_BLANK_EN suppresses leading zero digits (a lone '0' is always kept).
module bcd_ascii_streamer #(
    parameter int         pDigits = 4,
    parameter logic [7:0] pCR     = 8'h0D,
    parameter logic [7:0] pLF     = 8'h0A
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic [4*pDigits-1:0]   iBcd,
    input  logic                   iLoad,
    input  logic                   iReady,
    output logic [7:0]             oByte,
    output logic                   oValid,
    output logic                   oBusy,
    output logic                   oDropped
);

    localparam int IW = (pDigits > 1) ? $clog2(pDigits) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        CR,
        LF
    } state_t;

    state_t                 state;
    logic [4*pDigits-1:0]   digits;
    logic [IW-1:0]          index;
    logic [IW-1:0]          startIdx;
    logic                   transfer;

    function automatic logic [7:0] toAscii(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nibble});
    endfunction

    // Index of the first digit to send for the string currently on iBcd
    always_comb begin
        startIdx = IW'(pDigits - 1);
`ifdef BCD_LZ_BLANK_EN
        startIdx = '0;
        for (int k = 0; k < pDigits; k++) begin
            if (iBcd[4*k +: 4] != 4'd0) begin
                startIdx = IW'(k);
            end
        end
`endif
    end

    assign transfer = oValid && iReady;

    // Outputs are registered so the next byte is prepared on the same edge that consumes the current one
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state    <= IDLE;
            digits   <= '0;
            index    <= '0;
            oByte    <= 8'h00;
            oValid   <= 1'b0;
            oBusy    <= 1'b0;
            oDropped <= 1'b0;
        end else begin
            oDropped <= iLoad && (state != IDLE);
            case (state)
                IDLE: begin
                    if (iLoad) begin
                        digits <= iBcd;
                        index  <= startIdx;
                        oByte  <= toAscii(iBcd[{startIdx, 2'b00} +: 4]);
                        oValid <= 1'b1;
                        oBusy  <= 1'b1;
                        state  <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (transfer) begin
                        if (index == '0) begin
                            oByte <= pCR;
                            state <= CR;
                        end else begin
                            index <= index - 1'b1;
                            oByte <= toAscii(digits[{index - 1'b1, 2'b00} +: 4]);
                        end
                    end
                end
                CR: begin
                    if (transfer) begin
                        oByte <= pLF;
                        state <= LF;
                    end
                end
                LF: begin
                    if (transfer) begin
                        oByte  <= 8'h00;
                        oValid <= 1'b0;
                        oBusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
